// File: rtl/mips_run_ctrl.sv
// Run-control and completion monitor for the single-cycle MIPS core: reset
// sequencing, free-run/single-step clock enable, cycle counting and pass/fail/timeout.
module mips_run_ctrl #(
   parameter int                  RESET_CYCLES = 2,
   parameter int                  CYCLE_W      = 32,
   parameter int                  MAX_CYCLES   = 0,
   parameter int                  ADDR_W       = 32,
   parameter int                  DATA_W       = 32,
   parameter logic [ADDR_W-1:0]   DONE_ADDR    = 84,
   parameter logic [DATA_W-1:0]   DONE_DATA    = 7
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               step_mode,
   input  logic               step,
   input  logic               memwrite,
   input  logic [ADDR_W-1:0]  dataadr,
   input  logic [DATA_W-1:0]  writedata,
   output logic               cpu_reset,
   output logic               cpu_en,
   output logic [CYCLE_W-1:0] cycles,
   output logic [1:0]         state,
   output logic               pass,
   output logic               fail,
   output logic               timeout
);

   typedef enum logic [1:0] {
      ST_RST  = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int                 RC_W       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [RC_W-1:0]    RC_LAST    = RC_W'(RESET_CYCLES - 1);
   localparam bit                 TIMEOUT_EN = (MAX_CYCLES != 0);
   localparam logic [CYCLE_W-1:0] MAX_C      = CYCLE_W'(MAX_CYCLES);

   state_t             state_q, state_d;
   logic [RC_W-1:0]    rst_cnt_q, rst_cnt_d;
   logic               cpu_reset_q, cpu_reset_d;
   logic [CYCLE_W-1:0] cycles_q, cycles_d;
   logic               pass_q, pass_d;
   logic               fail_q, fail_d;
   logic               timeout_q, timeout_d;

   logic run_en;
   logic cnt_inc;
   logic done_hit;
   logic limit_hit;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      cpu_reset_d = cpu_reset_q;
      cycles_d    = cycles_q;
      pass_d      = pass_q;
      fail_d      = fail_q;
      timeout_d   = timeout_q;

      run_en    = (state_q == ST_RUN) || ((state_q == ST_STEP) && step);
      cnt_inc   = run_en && (cycles_q != '1);
      done_hit  = run_en && memwrite && (dataadr == DONE_ADDR);

      if (cnt_inc) begin
         cycles_d = cycles_q + CYCLE_W'(1);
      end

      // Timeout fires only on the increment that lands exactly on the limit.
      limit_hit = TIMEOUT_EN && cnt_inc && (cycles_d == MAX_C);

      case (state_q)
         ST_RST: begin
            if (rst_cnt_q == RC_LAST) begin
               cpu_reset_d = 1'b0;
               state_d     = step_mode ? ST_STEP : ST_RUN;
            end else begin
               rst_cnt_d = rst_cnt_q + RC_W'(1);
            end
         end
         ST_RUN, ST_STEP: begin
            if (done_hit) begin
               pass_d  = (writedata == DONE_DATA);
               fail_d  = (writedata != DONE_DATA);
               state_d = ST_DONE;
            end else if (limit_hit) begin
               timeout_d = 1'b1;
               state_d   = ST_DONE;
            end else begin
               state_d = step_mode ? ST_STEP : ST_RUN;
            end
         end
         default: begin
            cpu_reset_d = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_RST;
         rst_cnt_q   <= '0;
         cpu_reset_q <= 1'b1;
         cycles_q    <= '0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         cpu_reset_q <= cpu_reset_d;
         cycles_q    <= cycles_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         timeout_q   <= timeout_d;
      end
   end

   assign cpu_reset = cpu_reset_q;
   assign cpu_en    = run_en;
   assign cycles    = cycles_q;
   assign state     = state_q;
   assign pass      = pass_q;
   assign fail      = fail_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl: default, MAX_CYCLES=20 and CYCLE_W=4 instances
// share one stimulus stream; inputs change and outputs are sampled on the falling edge.
module tb_mips_run_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        step_mode;
   logic        step;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;

   logic        d_cpu_reset, d_cpu_en, d_pass, d_fail, d_timeout;
   logic [31:0] d_cycles;
   logic [1:0]  d_state;

   logic        t_cpu_reset, t_cpu_en, t_pass, t_fail, t_timeout;
   logic [31:0] t_cycles;
   logic [1:0]  t_state;

   logic        s_cpu_reset, s_cpu_en, s_pass, s_fail, s_timeout;
   logic [3:0]  s_cycles;
   logic [1:0]  s_state;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   mips_run_ctrl u_def (
      .clk(clk), .reset(reset), .step_mode(step_mode), .step(step),
      .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
      .cpu_reset(d_cpu_reset), .cpu_en(d_cpu_en), .cycles(d_cycles), .state(d_state),
      .pass(d_pass), .fail(d_fail), .timeout(d_timeout)
   );

   mips_run_ctrl #(.MAX_CYCLES(20)) u_to (
      .clk(clk), .reset(reset), .step_mode(step_mode), .step(step),
      .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
      .cpu_reset(t_cpu_reset), .cpu_en(t_cpu_en), .cycles(t_cycles), .state(t_state),
      .pass(t_pass), .fail(t_fail), .timeout(t_timeout)
   );

   mips_run_ctrl #(.CYCLE_W(4)) u_sat (
      .clk(clk), .reset(reset), .step_mode(step_mode), .step(step),
      .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
      .cpu_reset(s_cpu_reset), .cpu_en(s_cpu_en), .cycles(s_cycles), .state(s_state),
      .pass(s_pass), .fail(s_fail), .timeout(s_timeout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_wr(input logic we, input logic [31:0] a, input logic [31:0] d);
      memwrite  = we;
      dataadr   = a;
      writedata = d;
   endtask

   // Asynchronous reset from any state, then a two-edge release into RUN or STEP.
   task automatic restart(input logic sm, input string tag);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check({tag, "_rst_state"},  32'(d_state), 32'd0);
      check({tag, "_rst_cpurst"}, 32'(d_cpu_reset), 32'd1);
      check({tag, "_rst_cycles"}, d_cycles, 32'd0);
      check({tag, "_rst_flags"},  {29'd0, d_pass, d_fail, d_timeout}, 32'd0);
      check({tag, "_rst_en"},     32'(d_cpu_en), 32'd0);
      step_mode = sm;
      @(negedge clk);
      reset = 1'b0;
      tick(1);
      check({tag, "_edge1_cpurst"}, 32'(d_cpu_reset), 32'd1);
      tick(1);
      check({tag, "_edge2_cpurst"}, 32'(d_cpu_reset), 32'd0);
      check({tag, "_edge2_state"},  32'(d_state), sm ? 32'd2 : 32'd1);
   endtask

   initial begin
      reset     = 1'b1;
      step_mode = 1'b0;
      step      = 1'b0;
      set_wr(1'b0, 32'd0, 32'd0);

      // Reset release: 22 ns reset, edges at 25 and 35 hold then drop cpu_reset.
      #22;
      reset = 1'b0;
      #1;
      check("init_state",  32'(d_state), 32'd0);
      check("init_cpurst", 32'(d_cpu_reset), 32'd1);
      check("init_en",     32'(d_cpu_en), 32'd0);
      check("init_flags",  {29'd0, d_pass, d_fail, d_timeout}, 32'd0);
      tick(1);
      check("rel_edge1_cpurst", 32'(d_cpu_reset), 32'd1);
      check("rel_edge1_state",  32'(d_state), 32'd0);
      tick(1);
      check("rel_edge2_cpurst", 32'(d_cpu_reset), 32'd0);
      check("rel_edge2_state",  32'(d_state), 32'd1);
      check("rel_edge2_en",     32'(d_cpu_en), 32'd1);
      check("rel_edge2_cycles", d_cycles, 32'd0);
      tick(10);
      check("run10_cycles", d_cycles, 32'd10);

      // Pass: a store to 80 is ignored; the 15th cycle stores 7 to 84.
      set_wr(1'b1, 32'd80, 32'd7);
      tick(1);
      check("wr80_cycles", d_cycles, 32'd11);
      check("wr80_pass",   32'(d_pass), 32'd0);
      check("wr80_state",  32'(d_state), 32'd1);
      set_wr(1'b0, 32'd0, 32'd0);
      tick(3);
      check("pre_pass_cycles", d_cycles, 32'd14);
      set_wr(1'b1, 32'd84, 32'd7);
      tick(1);
      set_wr(1'b0, 32'd0, 32'd0);
      #1;
      check("pass_pass",   32'(d_pass), 32'd1);
      check("pass_fail",   32'(d_fail), 32'd0);
      check("pass_tmo",    32'(d_timeout), 32'd0);
      check("pass_state",  32'(d_state), 32'd3);
      check("pass_en",     32'(d_cpu_en), 32'd0);
      check("pass_cycles", d_cycles, 32'd15);
      set_wr(1'b1, 32'd84, 32'd5);
      tick(3);
      set_wr(1'b0, 32'd0, 32'd0);
      check("done_hold_cycles", d_cycles, 32'd15);
      check("done_hold_flags",  {29'd0, d_pass, d_fail, d_timeout}, 32'd4);
      check("done_hold_cpurst", 32'(d_cpu_reset), 32'd0);

      // Reset from DONE, then fail on a wrong completion value.
      restart(1'b0, "fail");
      set_wr(1'b1, 32'd84, 32'd5);
      tick(1);
      set_wr(1'b0, 32'd0, 32'd0);
      check("fail_fail",   32'(d_fail), 32'd1);
      check("fail_pass",   32'(d_pass), 32'd0);
      check("fail_state",  32'(d_state), 32'd3);
      check("fail_cycles", d_cycles, 32'd1);

      // Single-step with gaps; a completion store without step is ignored.
      restart(1'b1, "step");
      check("step_idle_en", 32'(d_cpu_en), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step = 1'b1;
         #1;
         check("step_en_comb", 32'(d_cpu_en), 32'd1);
         tick(1);
         step = 1'b0;
         tick(1);
      end
      check("step3_cycles", d_cycles, 32'd3);
      check("step3_state",  32'(d_state), 32'd2);
      set_wr(1'b1, 32'd84, 32'd7);
      tick(1);
      check("step_gated_pass",  32'(d_pass), 32'd0);
      check("step_gated_state", 32'(d_state), 32'd2);
      step = 1'b1;
      tick(1);
      step = 1'b0;
      set_wr(1'b0, 32'd0, 32'd0);
      check("step_pass",   32'(d_pass), 32'd1);
      check("step_state",  32'(d_state), 32'd3);
      check("step_cycles", d_cycles, 32'd4);

      // Mode switches: STEP->RUN without executing, RUN->STEP still executes.
      restart(1'b1, "mode");
      step_mode = 1'b0;
      tick(1);
      check("mode_to_run_state",  32'(d_state), 32'd1);
      check("mode_to_run_cycles", d_cycles, 32'd0);
      step_mode = 1'b1;
      tick(1);
      check("mode_to_step_state",  32'(d_state), 32'd2);
      check("mode_to_step_cycles", d_cycles, 32'd1);

      // Completion coinciding with a step_mode change still goes to DONE.
      step_mode = 1'b0;
      step      = 1'b1;
      set_wr(1'b1, 32'd84, 32'd7);
      tick(1);
      step = 1'b0;
      set_wr(1'b0, 32'd0, 32'd0);
      check("mode_done_state", 32'(d_state), 32'd3);
      check("mode_done_pass",  32'(d_pass), 32'd1);

      // Timeout at 20 cycles, and saturation of the 4-bit counter.
      restart(1'b0, "tmo");
      tick(20);
      check("tmo_flag",    32'(t_timeout), 32'd1);
      check("tmo_pass",    32'(t_pass), 32'd0);
      check("tmo_cycles",  t_cycles, 32'd20);
      check("tmo_state",   32'(t_state), 32'd3);
      check("tmo_en",      32'(t_cpu_en), 32'd0);
      check("def_nolimit", 32'(d_state), 32'd1);
      check("def_cycles",  d_cycles, 32'd20);
      check("sat_cycles",  32'(s_cycles), 32'd15);
      tick(2);
      check("tmo_hold_cycles", t_cycles, 32'd20);
      check("sat_hold_cycles", 32'(s_cycles), 32'd15);
      check("sat_state",       32'(s_state), 32'd1);

      // Completion on cycle 20 beats the timeout.
      restart(1'b0, "prio");
      tick(19);
      check("prio_pre_cycles", t_cycles, 32'd19);
      set_wr(1'b1, 32'd84, 32'd7);
      tick(1);
      set_wr(1'b0, 32'd0, 32'd0);
      check("prio_pass",   32'(t_pass), 32'd1);
      check("prio_tmo",    32'(t_timeout), 32'd0);
      check("prio_cycles", t_cycles, 32'd20);
      check("prio_state",  32'(t_state), 32'd3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mips_run_ctrl.md
# mips_run_ctrl

Synthesisable run-control and completion monitor for the single-cycle MIPS core. It sequences the core's reset, gates the core clock enable for free-run or single-step execution, and counts executed cycles. It watches the data-memory write port for the program's completion store and flags pass, fail or timeout. It sits between the board/bench clock-reset source and `top`, replacing hand-written bench reset timing and cycle loops.

## Interface
Parameters:
- `RESET_CYCLES`, 2: number of cycles `cpu_reset` is held after `reset` releases; minimum 1.
- `CYCLE_W`, 32: width of the executed-cycle counter.
- `MAX_CYCLES`, 0: timeout limit in executed cycles; 0 disables the timeout.
- `ADDR_W`, 32: data address width.
- `DATA_W`, 32: write data width.
- `DONE_ADDR`, 84: address of the completion store.
- `DONE_DATA`, 7: data value that signals pass at `DONE_ADDR`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `step_mode` in 1: 1 selects single-step, 0 selects free-run.
- `step` in 1: in single-step, enables exactly one core cycle for each cycle it is high.
- `memwrite` in 1: core data-memory write strobe.
- `dataadr` in `ADDR_W`: core data address.
- `writedata` in `DATA_W`: core write data.
- `cpu_reset` out 1: registered reset to the core.
- `cpu_en` out 1: combinational clock enable to the core.
- `cycles` out `CYCLE_W`: executed-cycle count.
- `state` out 2: current state (0 RST, 1 RUN, 2 STEP, 3 DONE).
- `pass`, `fail`, `timeout` out 1 each: sticky result flags.

## Operation
- **Reset values** while `reset` is high: state=RST, internal reset counter=0, `cpu_reset`=1, `cycles`=0, `pass`=`fail`=`timeout`=0, `cpu_en`=0.
- **RST**
  - The reset counter increments every cycle.
  - When it reaches `RESET_CYCLES`-1: `cpu_reset` goes to 0 and the state goes to STEP if `step_mode`=1, otherwise to RUN.
- **RUN**
  - `cpu_en`=1.
  - If `step_mode`=1, the next state is STEP. The current cycle still executes.
- **STEP**
  - `cpu_en`=`step`.
  - If `step_mode`=0, the next state is RUN.
- **DONE**
  - `cpu_en`=0 and `cpu_reset`=0.
  - Sticky until `reset`; all flags and `cycles` hold.
- **Cycle counter:** on every edge where `cpu_en`=1, `cycles` increments by 1. It saturates at all-ones and never wraps.
- **Completion check**, evaluated only when `cpu_en`=1 and `memwrite`=1 and `dataadr`==`DONE_ADDR`:
  - `writedata`==`DONE_DATA` sets `pass`.
  - Any other `writedata` sets `fail`.
  - Either case moves the state to DONE.
  - Writes to other addresses are ignored.
  - `memwrite` while `cpu_en`=0 is ignored.
- **Timeout:** if `MAX_CYCLES`≠0 and an enabled cycle brings `cycles` to `MAX_CYCLES` with no completion in that cycle, set `timeout` and move to DONE.
- **Simultaneous events:**
  - Completion and timeout in the same cycle: completion wins, so `timeout` stays 0.
  - Completion in the same cycle as a `step_mode` change: the state goes to DONE.
- At most one of `pass`/`fail`/`timeout` is ever set.

## Timing
- `cpu_reset` is high from `reset` assertion until the `RESET_CYCLES`-th rising edge after `reset` deasserts.
- The first core instruction executes on the edge after `cpu_reset` falls.
- `cpu_en` is a combinational function of state and `step`, so it has zero latency from `step`.
- `cycles`, the flags and `state` update on the same edge as the qualifying enabled cycle. Values are visible in the following cycle.
- After k enabled cycles, `cycles`=k.
- **Reset mid-operation:** asynchronous return to all reset values regardless of state, including DONE. The reset sequence restarts.

## Test plan
- **Reset release:** `RESET_CYCLES`=2, assert `reset` for 22 ns at a 10 ns clock period, `step_mode`=0 → `cpu_reset` high through exactly 2 edges after release; state=RUN; `cpu_en`=1; after 10 more edges `cycles`=10.
- **Pass:** free-run, then drive `memwrite`=1, `dataadr`=84, `writedata`=7 on cycle 15 → `pass`=1, state=DONE, `cpu_en`=0, `cycles` frozen at 15. A write to address 80 earlier in the run has no effect.
- **Fail:** `memwrite`=1, `dataadr`=84, `writedata`=5 → `fail`=1, `pass`=0, state=DONE.
- **Single-step:** `step_mode`=1, pulse `step` 3 times with gaps → `cycles`=3. A `memwrite` to 84/7 while `step`=0 is ignored; the same write with `step`=1 sets `pass`.
- **Timeout and priority:**
  - `MAX_CYCLES`=20 with no completion → `timeout`=1 with `cycles`=20.
  - A completion write on cycle 20 instead → `pass`=1 and `timeout`=0.
- **Mid-run reset and saturation:**
  - Assert `reset` in DONE → all outputs return to reset values; the sequence repeats identically.
  - With `CYCLE_W`=4, 20 free-run cycles → `cycles`=15.
